eth_mii_frame_rx: RTL and testbench

ETH_MII_FRAME_RX -- requirements
Module: eth_mii_frame_rx

---
 rtl/eth_mii_frame_rx.sv | 169 ++++++++++++++++
 tb/tb_eth_mii_frame_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mii_frame_rx.sv
// MII-style byte-stream frame receiver: start/preamble/SFD tracking, payload strobe, length check.
// Optional frame/error statistics counters are built when ETH_MII_RX_STATS_EN is defined.
module eth_mii_frame_rx #(
  parameter int          PREAMBLE_CYCLES = 6,
  parameter int          MIN_DATA        = 46,
  parameter int          MAX_DATA        = 1500,
  parameter logic [7:0]  IDLE_CODE       = 8'h07,
  parameter logic [7:0]  START_CODE      = 8'hFB,
  parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
  parameter logic [7:0]  SFD_CODE        = 8'hD5,
  parameter logic [7:0]  TERMINATE_CODE  = 8'hFD
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_ctrl,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_frame_ok,
  output logic [15:0] o_len,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam logic [15:0] MIN_L    = 16'(MIN_DATA);
  localparam logic [15:0] MAX_L    = 16'(MAX_DATA);
  localparam logic [15:0] LEN_SAT  = 16'(MAX_DATA + 1);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_DROP
  } state_t;

  state_t      state, state_n;
  logic [7:0]  pre_cnt, pre_cnt_n;
  logic [15:0] len, len_n;
  logic [7:0]  data_n;
  logic        valid_n, sof_n, eof_n, ok_n;
  logic [15:0] olen_n;

  logic is_start, is_pre, is_sfd, is_term, is_idle;

  assign is_start = i_rx_ctrl && (i_rx_data == START_CODE);
  assign is_term  = i_rx_ctrl && (i_rx_data == TERMINATE_CODE);
  assign is_idle  = i_rx_ctrl && (i_rx_data == IDLE_CODE);
  assign is_pre   = !i_rx_ctrl && (i_rx_data == PREAMBLE_CODE);
  assign is_sfd   = !i_rx_ctrl && (i_rx_data == SFD_CODE);

  always_comb begin
    state_n   = state;
    pre_cnt_n = pre_cnt;
    len_n     = len;
    data_n    = 8'h00;
    valid_n   = 1'b0;
    sof_n     = 1'b0;
    eof_n     = 1'b0;
    ok_n      = 1'b0;
    olen_n    = 16'h0000;
    unique case (state)
      S_IDLE: begin
        if (is_start) begin
          state_n   = S_PREAMBLE;
          pre_cnt_n = 8'h00;
          len_n     = 16'h0000;
        end
      end
      S_PREAMBLE: begin
        if (is_pre) begin
          if (pre_cnt == PRE_LAST) state_n = S_SFD;
          else pre_cnt_n = pre_cnt + 8'h01;
        end else begin
          state_n = S_DROP;
          eof_n   = 1'b1;
        end
      end
      S_SFD: begin
        if (is_sfd) begin
          state_n = S_DATA;
          len_n   = 16'h0000;
        end else begin
          state_n = S_DROP;
          eof_n   = 1'b1;
        end
      end
      S_DATA: begin
        if (!i_rx_ctrl) begin
          data_n  = i_rx_data;
          valid_n = 1'b1;
          sof_n   = (len == 16'h0000);
          len_n   = (len >= LEN_SAT) ? LEN_SAT : len + 16'h0001;
          // oversize is flagged on the byte that crosses the limit
          if (len_n > MAX_L) begin
            state_n = S_DROP;
            eof_n   = 1'b1;
            olen_n  = len_n;
          end
        end else if (is_term) begin
          state_n = S_IDLE;
          eof_n   = 1'b1;
          olen_n  = len;
          ok_n    = (len >= MIN_L) && (len <= MAX_L);
        end else begin
          state_n = S_DROP;
          eof_n   = 1'b1;
          olen_n  = len;
        end
      end
      S_DROP: begin
        if (is_start) begin
          state_n   = S_PREAMBLE;
          pre_cnt_n = 8'h00;
          len_n     = 16'h0000;
        end else if (is_term || is_idle) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      pre_cnt    <= 8'h00;
      len        <= 16'h0000;
      o_data     <= 8'h00;
      o_valid    <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_frame_ok <= 1'b0;
      o_len      <= 16'h0000;
    end else begin
      state      <= state_n;
      pre_cnt    <= pre_cnt_n;
      len        <= len_n;
      o_data     <= data_n;
      o_valid    <= valid_n;
      o_sof      <= sof_n;
      o_eof      <= eof_n;
      o_frame_ok <= ok_n;
      o_len      <= olen_n;
    end
  end

`ifdef ETH_MII_RX_STATS_EN
  // counters move together with the o_eof they account for
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_frame_cnt <= 16'h0000;
      o_err_cnt   <= 16'h0000;
    end else if (eof_n) begin
      if (ok_n && o_frame_cnt != 16'hFFFF)
        o_frame_cnt <= o_frame_cnt + 16'h0001;
      if (!ok_n && o_err_cnt != 16'hFFFF)
        o_err_cnt <= o_err_cnt + 16'h0001;
    end
  end
`else
  assign o_frame_cnt = 16'h0000;
  assign o_err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_mii_frame_rx.sv
// Bench for eth_mii_frame_rx: frame table plus scoreboard of expected payload/eof events.
module tb_eth_mii_frame_rx;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_ctrl;
  logic [7:0]  o_data;
  logic        o_valid, o_sof, o_eof, o_frame_ok;
  logic [15:0] o_len, o_frame_cnt, o_err_cnt;

  always #5 clk = ~clk;

  eth_mii_frame_rx dut (
    .clk(clk),
    .i_rst(i_rst),
    .i_rx_data(i_rx_data),
    .i_rx_ctrl(i_rx_ctrl),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_sof(o_sof),
    .o_eof(o_eof),
    .o_frame_ok(o_frame_ok),
    .o_len(o_len),
    .o_frame_cnt(o_frame_cnt),
    .o_err_cnt(o_err_cnt)
  );

  typedef struct {
    int         n_data;
    int         bad_pre;
    int         err_at;
    logic [7:0] err_code;
    bit         exp_ok;
    int         exp_len;
    bit         chk_len;
  } vec_t;

  typedef struct {
    bit         is_eof;
    logic [7:0] data;
    bit         sof;
    bit         ok;
    int         len;
    bit         chk_len;
  } exp_t;

  localparam int NVEC = 10;
  localparam int OVER = 1501;

  exp_t sbq[$];
  vec_t vecs[NVEC];
  int   total = 0;
  int   bad = 0;
  int   exp_good = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [7:0] d);
    i_rx_ctrl = c;
    i_rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_data(input logic [7:0] d, input bit sof);
    exp_t e;
    e = '{is_eof: 1'b0, data: d, sof: sof, ok: 1'b0, len: 0, chk_len: 1'b0};
    sbq.push_back(e);
  endtask

  task automatic push_eof(input bit ok, input int len, input bit cl);
    exp_t e;
    e = '{is_eof: 1'b1, data: 8'h00, sof: 1'b0, ok: ok, len: len, chk_len: cl};
    sbq.push_back(e);
    if (ok) exp_good++;
    else exp_err++;
  endtask

  task automatic send_frame(input vec_t v, input int n_idle);
    bit dropped;
    int cnt;
    dropped = 1'b0;
    cnt = 0;
    repeat (n_idle) drive(1'b1, 8'h07);
    drive(1'b1, 8'hFB);
    for (int p = 0; p < 6; p++) begin
      if (!dropped && v.bad_pre == p + 1) begin
        push_eof(v.exp_ok, v.exp_len, v.chk_len);
        dropped = 1'b1;
        drive(1'b0, 8'h54);
      end else begin
        drive(1'b0, 8'h55);
      end
    end
    drive(1'b0, 8'hD5);
    for (int i = 0; i < v.n_data; i++) begin
      if (!dropped && i == v.err_at) begin
        push_eof(v.exp_ok, v.exp_len, v.chk_len);
        dropped = 1'b1;
        drive(1'b1, v.err_code);
        break;
      end
      if (!dropped) begin
        push_data(8'(i), i == 0);
        cnt++;
        if (cnt == OVER) begin
          push_eof(v.exp_ok, v.exp_len, v.chk_len);
          dropped = 1'b1;
        end
      end
      drive(1'b0, 8'(i));
    end
    if (!dropped) push_eof(v.exp_ok, v.exp_len, v.chk_len);
    drive(1'b1, 8'hFD);
  endtask

  task automatic check_counters(input string tag);
    repeat (3) drive(1'b1, 8'h07);
`ifdef ETH_MII_RX_STATS_EN
    chk({tag, "_frame_cnt"}, {16'h0, o_frame_cnt}, exp_good);
    chk({tag, "_err_cnt"}, {16'h0, o_err_cnt}, exp_err);
`else
    chk({tag, "_frame_cnt"}, {16'h0, o_frame_cnt}, 32'h0);
    chk({tag, "_err_cnt"}, {16'h0, o_err_cnt}, 32'h0);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      if (sbq.size() == 0 || sbq[0].is_eof) begin
        chk("valid_unexpected", {31'h0, o_valid}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("data", {24'h0, o_data}, {24'h0, e.data});
        chk("sof", {31'h0, o_sof}, {31'h0, e.sof});
      end
    end else if (o_sof) begin
      chk("sof_without_valid", {31'h0, o_sof}, 32'h0);
    end
    if (o_eof) begin
      if (sbq.size() == 0 || !sbq[0].is_eof) begin
        chk("eof_unexpected", {31'h0, o_eof}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("frame_ok", {31'h0, o_frame_ok}, {31'h0, e.ok});
        if (e.chk_len) chk("len", {16'h0, o_len}, e.len);
      end
    end
  end

  initial begin
    vecs[0] = '{46, 0, -1, 8'h00, 1'b1, 46, 1'b1};
    vecs[1] = '{45, 0, -1, 8'h00, 1'b0, 45, 1'b1};
    vecs[2] = '{46, 3, -1, 8'h00, 1'b0, 0, 1'b0};
    vecs[3] = '{OVER, 0, -1, 8'h00, 1'b0, OVER, 1'b0};
    vecs[4] = '{46, 0, -1, 8'h00, 1'b1, 46, 1'b1};
    vecs[5] = '{1500, 0, -1, 8'h00, 1'b1, 1500, 1'b1};
    vecs[6] = '{47, 0, -1, 8'h00, 1'b1, 47, 1'b1};
    vecs[7] = '{30, 0, 10, 8'h07, 1'b0, 10, 1'b0};
    vecs[8] = '{30, 0, 5, 8'hFB, 1'b0, 5, 1'b0};
    vecs[9] = '{0, 0, -1, 8'h00, 1'b0, 0, 1'b1};

    i_rst = 1'b1;
    i_rx_ctrl = 1'b1;
    i_rx_data = 8'h07;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {4'h0, o_data, o_valid, o_sof, o_eof, o_frame_ok, o_len}, 32'h0);
    chk("reset_counters", {o_frame_cnt, o_err_cnt}, 32'h0);
    i_rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      send_frame(vecs[k], 12);
      check_counters($sformatf("vec%0d", k));
    end

    // error in preamble followed directly by a new start code
    repeat (4) drive(1'b1, 8'h07);
    drive(1'b1, 8'hFB);
    drive(1'b0, 8'h55);
    push_eof(1'b0, 0, 1'b0);
    drive(1'b0, 8'h54);
    send_frame(vecs[0], 0);
    check_counters("drop_restart");

    // reset while the 20th payload byte is on the line
    repeat (12) drive(1'b1, 8'h07);
    drive(1'b1, 8'hFB);
    repeat (6) drive(1'b0, 8'h55);
    drive(1'b0, 8'hD5);
    for (int i = 0; i < 19; i++) begin
      push_data(8'(i), i == 0);
      drive(1'b0, 8'(i));
    end
    i_rst = 1'b1;
    drive(1'b0, 8'd19);
    chk("midrst_outputs",
        {4'h0, o_data, o_valid, o_sof, o_eof, o_frame_ok, o_len}, 32'h0);
    chk("midrst_counters", {o_frame_cnt, o_err_cnt}, 32'h0);
    chk("midrst_sb_empty", sbq.size(), 32'h0);
    drive(1'b0, 8'd20);
    i_rst = 1'b0;
    exp_good = 0;
    exp_err = 0;
    repeat (2) drive(1'b0, 8'd21);
    send_frame(vecs[0], 12);
    check_counters("after_reset");

    repeat (5) drive(1'b1, 8'h07);
    chk("sb_empty_end", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
